// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encodings,
// multiply-latency bounds, counter width and the NOP instruction word.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_MUL_BUSY = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam int          MUL_LAT_MIN = 1;
    localparam int          MUL_LAT_MAX = 16;
    localparam int          MCNT_W      = 4;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;

endpackage

// File: rtl/load_use_cmp.sv
// Load-use hazard comparator: the EX-stage load writes a register that the
// decode-stage instruction reads. r0 is hardwired and never a hazard.
module load_use_cmp #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] i_op1_buf1,
    input  logic [REG_W-1:0] i_op2_buf1,
    input  logic             i_uses_op2,
    input  logic [REG_W-1:0] i_dest_buf2,
    input  logic             i_regwr_buf2,
    input  logic             i_memrd_buf2,
    output logic             o_lu
);

    logic w_is_load;
    logic w_dest_nz;
    logic w_hit_op1;
    logic w_hit_op2;

    assign w_is_load = i_memrd_buf2 & i_regwr_buf2;
    assign w_dest_nz = |i_dest_buf2;
    assign w_hit_op1 = (i_dest_buf2 == i_op1_buf1);
    assign w_hit_op2 = i_uses_op2 & (i_dest_buf2 == i_op2_buf1);
    assign o_lu      = w_is_load & w_dest_nz & (w_hit_op1 | w_hit_op2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, multi-cycle multiply hold
// and taken-branch flush. Optional stall counter under `HAZ_STATS_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLOCK,
    input  logic             in_rst,
    input  logic [REG_W-1:0] in_op1_buf1,
    input  logic [REG_W-1:0] in_op2_buf1,
    input  logic             in_uses_op2,
    input  logic [REG_W-1:0] in_dest_buf2,
    input  logic             in_regwr_buf2,
    input  logic             in_memrd_buf2,
    input  logic             in_mul_buf2,
    input  logic             in_br_taken,
    output logic             out_pc_en,
    output logic             out_buf1_en,
    output logic             out_buf2_en,
    output logic             out_flush1,
    output logic             out_bubble2,
    output logic             out_bubble3,
`ifdef HAZ_STATS_EN
    output logic [CNT_W-1:0] out_stall_cnt,
`endif
    output logic [1:0]       out_state
);

    generate
        if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX || CNT_W < 1) begin : g_bad_param
            $error("hazard_stall_ctrl: parameter out of range");
        end
    endgenerate

    // Multiply trigger cycle counts as one EX cycle, release cycle as another.
    localparam logic [MCNT_W-1:0] MCNT_INIT =
        (MUL_LAT > 1) ? MCNT_W'(MUL_LAT - 2) : '0;
    localparam logic MUL_STALLS = (MUL_LAT > 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MCNT_W-1:0] r_mcnt;
    logic [MCNT_W-1:0] w_mcnt_nxt;
    logic              w_lu;
    logic              w_pc_en;
    logic              w_buf1_en;
    logic              w_buf2_en;
    logic              w_flush1;
    logic              w_bubble2;
    logic              w_bubble3;

    load_use_cmp #(.REG_W(REG_W)) u_load_use_cmp (
        .i_op1_buf1   (in_op1_buf1),
        .i_op2_buf1   (in_op2_buf1),
        .i_uses_op2   (in_uses_op2),
        .i_dest_buf2  (in_dest_buf2),
        .i_regwr_buf2 (in_regwr_buf2),
        .i_memrd_buf2 (in_memrd_buf2),
        .o_lu         (w_lu)
    );

    always_ff @(posedge CLOCK or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= ST_RUN;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        w_pc_en     = 1'b1;
        w_buf1_en   = 1'b1;
        w_buf2_en   = 1'b1;
        w_flush1    = 1'b0;
        w_bubble2   = 1'b0;
        w_bubble3   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (in_br_taken) begin
                    w_flush1  = 1'b1;
                    w_bubble2 = 1'b1;
                end else if (in_mul_buf2 && MUL_STALLS) begin
                    w_pc_en     = 1'b0;
                    w_buf1_en   = 1'b0;
                    w_buf2_en   = 1'b0;
                    w_bubble3   = 1'b1;
                    w_mcnt_nxt  = MCNT_INIT;
                    w_state_nxt = ST_MUL_BUSY;
                end else if (w_lu) begin
                    w_pc_en     = 1'b0;
                    w_buf1_en   = 1'b0;
                    w_bubble2   = 1'b1;
                    w_state_nxt = ST_LD_STALL;
                end
            end
            ST_LD_STALL: begin
                w_state_nxt = ST_RUN;
            end
            ST_MUL_BUSY: begin
                if (r_mcnt != '0) begin
                    w_pc_en    = 1'b0;
                    w_buf1_en  = 1'b0;
                    w_buf2_en  = 1'b0;
                    w_bubble3  = 1'b1;
                    w_mcnt_nxt = r_mcnt - 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_mcnt_nxt  = '0;
            end
        endcase
    end

    // Reset forces every control low combinationally, not just the state.
    assign out_pc_en   = in_rst & w_pc_en;
    assign out_buf1_en = in_rst & w_buf1_en;
    assign out_buf2_en = in_rst & w_buf2_en;
    assign out_flush1  = in_rst & w_flush1;
    assign out_bubble2 = in_rst & w_bubble2;
    assign out_bubble3 = in_rst & w_bubble3;
    assign out_state   = in_rst ? r_state : ST_RUN;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge CLOCK or negedge in_rst) begin
        if (!in_rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MUL_LAT = 4).
// Output vector order: {pc_en, buf1_en, buf2_en, flush1, bubble2, bubble3}.
module tb_hazard_stall_ctrl;

    localparam logic [5:0] O_DEF = 6'b111000;
    localparam logic [5:0] O_LU  = 6'b001010;
    localparam logic [5:0] O_MUL = 6'b000001;
    localparam logic [5:0] O_BR  = 6'b111110;
    localparam logic [5:0] O_RST = 6'b000000;

    logic       CLOCK;
    logic       in_rst;
    logic [3:0] in_op1_buf1, in_op2_buf1, in_dest_buf2;
    logic       in_uses_op2, in_regwr_buf2, in_memrd_buf2, in_mul_buf2, in_br_taken;
    logic       out_pc_en, out_buf1_en, out_buf2_en, out_flush1, out_bubble2, out_bubble3;
    logic [1:0] out_state;
    logic [5:0] w_outs;
`ifdef HAZ_STATS_EN
    logic [15:0] out_stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    hazard_stall_ctrl #(.REG_W(4), .MUL_LAT(4), .CNT_W(16)) dut (
        .CLOCK         (CLOCK),
        .in_rst        (in_rst),
        .in_op1_buf1   (in_op1_buf1),
        .in_op2_buf1   (in_op2_buf1),
        .in_uses_op2   (in_uses_op2),
        .in_dest_buf2  (in_dest_buf2),
        .in_regwr_buf2 (in_regwr_buf2),
        .in_memrd_buf2 (in_memrd_buf2),
        .in_mul_buf2   (in_mul_buf2),
        .in_br_taken   (in_br_taken),
        .out_pc_en     (out_pc_en),
        .out_buf1_en   (out_buf1_en),
        .out_buf2_en   (out_buf2_en),
        .out_flush1    (out_flush1),
        .out_bubble2   (out_bubble2),
        .out_bubble3   (out_bubble3),
`ifdef HAZ_STATS_EN
        .out_stall_cnt (out_stall_cnt),
`endif
        .out_state     (out_state)
    );

    assign w_outs = {out_pc_en, out_buf1_en, out_buf2_en, out_flush1, out_bubble2, out_bubble3};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clr();
        in_op1_buf1   = 4'd0;
        in_op2_buf1   = 4'd0;
        in_dest_buf2  = 4'd0;
        in_uses_op2   = 1'b0;
        in_regwr_buf2 = 1'b0;
        in_memrd_buf2 = 1'b0;
        in_mul_buf2   = 1'b0;
        in_br_taken   = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] dest);
        in_memrd_buf2 = 1'b1;
        in_regwr_buf2 = 1'b1;
        in_dest_buf2  = dest;
    endtask

    initial begin
        int stalls;
        clr();
        in_rst = 1'b0;
        #2;
        chk("rst_outs", 32'(w_outs), 32'(O_RST));
        chk("rst_state", 32'(out_state), 32'd0);
        tick();
        tick();
        in_rst = 1'b1;
        #2;
        chk("idle_outs", 32'(w_outs), 32'(O_DEF));

        // r0 destination never stalls
        set_load(4'd0);
        in_op1_buf1 = 4'd0;
        #2;
        chk("r0_outs", 32'(w_outs), 32'(O_DEF));
        tick();
        chk("r0_state", 32'(out_state), 32'd0);

        // op2 match ignored unless op2 is used
        clr();
        set_load(4'd4);
        in_op1_buf1 = 4'd1;
        in_op2_buf1 = 4'd4;
        #2;
        chk("op2_unused", 32'(w_outs), 32'(O_DEF));
        in_uses_op2 = 1'b1;
        #1;
        chk("op2_used", 32'(w_outs), 32'(O_LU));
        tick();
        chk("op2_ld_state", 32'(out_state), 32'd1);
        chk("ld_suppress", 32'(w_outs), 32'(O_DEF));
        clr();
        tick();
        chk("op2_back_run", 32'(out_state), 32'd0);

        // load-use on op1
        set_load(4'd5);
        in_op1_buf1 = 4'd5;
        #2;
        chk("lu_outs", 32'(w_outs), 32'(O_LU));
        chk("lu_state0", 32'(out_state), 32'd0);
        tick();
        clr();
        #1;
        chk("lu_state1", 32'(out_state), 32'd1);
        chk("lu_def1", 32'(w_outs), 32'(O_DEF));
        tick();
        chk("lu_state2", 32'(out_state), 32'd0);

        // branch beats both load-use and multiply
        set_load(4'd5);
        in_op1_buf1 = 4'd5;
        in_br_taken = 1'b1;
        #2;
        chk("br_over_lu", 32'(w_outs), 32'(O_BR));
        in_mul_buf2 = 1'b1;
        #1;
        chk("br_over_mul", 32'(w_outs), 32'(O_BR));
        tick();
        chk("br_state", 32'(out_state), 32'd0);
        clr();

        // multiply, MUL_LAT = 4, with a back-to-back second multiply
        in_mul_buf2 = 1'b1;
        #2;
        chk("mul_c1", 32'(w_outs), 32'(O_MUL));
        chk("mul_c1_st", 32'(out_state), 32'd0);
        tick();
        in_br_taken = 1'b1;
        set_load(4'd5);
        in_op1_buf1 = 4'd5;
        #1;
        chk("mul_c2_ign", 32'(w_outs), 32'(O_MUL));
        chk("mul_c2_st", 32'(out_state), 32'd2);
        tick();
        clr();
        in_mul_buf2 = 1'b1;
        #1;
        chk("mul_c3", 32'(w_outs), 32'(O_MUL));
        tick();
        #1;
        chk("mul_rel", 32'(w_outs), 32'(O_DEF));
        chk("mul_rel_st", 32'(out_state), 32'd2);
        tick();
        #1;
        chk("mul2_trig", 32'(w_outs), 32'(O_MUL));
        chk("mul2_st", 32'(out_state), 32'd0);
        tick();
        tick();
        tick();
        chk("mul2_rel", 32'(w_outs), 32'(O_DEF));
        in_mul_buf2 = 1'b0;
        tick();
        chk("mul2_run", 32'(out_state), 32'd0);

        // reset during the second MUL_BUSY cycle
        in_mul_buf2 = 1'b1;
        tick();
        tick();
        chk("pre_rst_st", 32'(out_state), 32'd2);
        in_rst = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(w_outs), 32'(O_RST));
        chk("rst_mid_st", 32'(out_state), 32'd0);
        in_mul_buf2 = 1'b0;
        tick();
        in_rst = 1'b1;
        #1;
        chk("rel_st", 32'(out_state), 32'd0);
        chk("rel_outs", 32'(w_outs), 32'(O_DEF));
`ifdef HAZ_STATS_EN
        chk("cnt_clr", 32'(out_stall_cnt), 32'd0);
`endif

        // fresh multiply must stall the full latency
        in_mul_buf2 = 1'b1;
        stalls = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (out_pc_en !== 1'b0) break;
            stalls++;
            tick();
            #1;
        end
        chk("fresh_stalls", 32'(stalls), 32'd3);
        chk("fresh_rel_st", 32'(out_state), 32'd2);
        in_mul_buf2 = 1'b0;
        tick();
        chk("fresh_run", 32'(out_state), 32'd0);

        // one load-use stall on top of the multiply
        set_load(4'd3);
        in_op1_buf1 = 4'd3;
        tick();
        clr();
        tick();
`ifdef HAZ_STATS_EN
        chk("stall_cnt", 32'(out_stall_cnt), 32'd4);
`endif
        chk("final_st", 32'(out_state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 16-bit, 4-bit-register-id pipelined processor. It detects load-use hazards between the decode stage (buffer 1) and the execute stage (buffer 2), and holds the front end while a multi-cycle multiply occupies EX. It also flushes wrong-path instructions on a taken branch resolved in EX. It drives the PC and pipeline-buffer enables and the bubble/flush controls, and works alongside the forwarding unit, which covers all non-load RAW hazards.

## Interface
- `REG_W`, 4: register-id width.
- `MUL_LAT`, 4: EX occupancy of a multiply in cycles, range 1..16; a value of 1 means no stall.
- `CNT_W`, 16: stall-counter width (only with the macro).

- `CLOCK` in 1: single clock, rising edge.
- `in_rst` in 1: asynchronous, active-low reset.
- `in_op1_buf1` in REG_W: decode-stage source register 1.
- `in_op2_buf1` in REG_W: decode-stage source register 2.
- `in_uses_op2` in 1: the decode instruction reads op2.
- `in_dest_buf2` in REG_W: destination register of the EX instruction.
- `in_regwr_buf2` in 1: the EX instruction writes a register.
- `in_memrd_buf2` in 1: the EX instruction is a load.
- `in_mul_buf2` in 1: the EX instruction is a multiply.
- `in_br_taken` in 1: a branch in EX resolved as taken.
- `out_pc_en` out 1: PC write enable.
- `out_buf1_en` out 1: IF/ID write enable.
- `out_buf2_en` out 1: ID/EX write enable.
- `out_flush1` out 1: clear IF/ID to NOP.
- `out_bubble2` out 1: load NOP into ID/EX.
- `out_bubble3` out 1: load NOP into EX/MEM.
- `out_state` out 2: current FSM state.

## Operation
- FSM states:
  - RUN = 00
  - LD_STALL = 01
  - MUL_BUSY = 10
  - 11 is illegal and recovers to RUN on the next edge.
- Down-counter `mcnt`, 4 bits.
- Default outputs (normal flow): all three enables = 1; flush and bubbles = 0.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `in_memrd_buf2` and `in_regwr_buf2` are both 1;
  - `in_dest_buf2` != 0 (r0 is never a hazard);
  - `in_dest_buf2` == `in_op1_buf1`, or (`in_uses_op2` and `in_dest_buf2` == `in_op2_buf1`).
- RUN: events are evaluated in strict priority order.
  1. `in_br_taken`: `out_flush1` = 1, `out_bubble2` = 1, `out_pc_en` = 1 (PC loads the target). Stay in RUN.
  2. `in_mul_buf2` and `MUL_LAT` > 1: `out_pc_en`, `out_buf1_en` and `out_buf2_en` = 0; `out_bubble3` = 1; `mcnt` <= `MUL_LAT`-2. Go to MUL_BUSY.
  3. `lu`: `out_pc_en` and `out_buf1_en` = 0; `out_bubble2` = 1. Go to LD_STALL.
  4. Otherwise: defaults.
- LD_STALL: defaults; all detection is suppressed. Return to RUN unconditionally. The load is now in MEM and the forwarding unit supplies its data.
- MUL_BUSY:
  - `in_br_taken` and `lu` are ignored.
  - If `mcnt` != 0: hold outputs as in RUN item 2, and `mcnt` decrements.
  - If `mcnt` == 0 (release cycle): defaults, so the product enters EX/MEM. Go to RUN.
  - `in_mul_buf2` is still high during the release cycle and must not re-trigger.
- Total EX occupancy of a multiply is exactly `MUL_LAT` cycles.
- Two back-to-back multiplies each stall for the full `MUL_LAT`.

## Timing
- State and `mcnt` are registered on the `CLOCK` rising edge.
- Outputs are combinational from the state, `mcnt` and the same-cycle inputs, with zero-cycle response.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 2 squashed slots with no extra state.
- While `in_rst` = 0, asynchronously:
  - state = RUN, `mcnt` = 0;
  - all enables = 0, flush and bubbles = 0, `out_state` = 00.
- Reset asserted mid-MUL_BUSY or mid-LD_STALL aborts immediately. On the first edge after deassertion the controller evaluates in RUN.
- X on any input must not propagate into the state; the implementation uses an explicit default branch.

## Configuration
- `HAZ_STATS_EN` defined:
  - adds `out_stall_cnt` out `CNT_W`: counts cycles with `out_pc_en` = 0 while out of reset;
  - the counter saturates at all-ones and clears on reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- `hazard_pkg` holds the state encodings, `MUL_LAT` bounds, and the NOP instruction word (16'h0000).
- One sub-module, `load_use_cmp`, computes `lu` from the buffer-1 and buffer-2 fields.
- The FSM, counter and output decode stay in the top level.

## Test plan
- Load-use:
  - Stimulus: `in_memrd_buf2` = 1, `in_regwr_buf2` = 1, `in_dest_buf2` = 0101, `in_op1_buf1` = 0101.
  - Response: `out_pc_en` = 0, `out_buf1_en` = 0, `out_bubble2` = 1 that cycle; `out_state` = 01 next cycle with defaults; then 00.
- r0 and op2 gating:
  - Stimulus: `in_dest_buf2` = 0000 matching op1 → Response: no stall.
  - Stimulus: `in_dest_buf2` = 0100 = `in_op2_buf1` with `in_uses_op2` = 0 → Response: no stall.
- Multiply with `MUL_LAT` = 4:
  - Stimulus: `in_mul_buf2` = 1 held.
  - Response: enables low and `out_bubble3` = 1 for 3 cycles (`out_state` 00, 10, 10); release in cycle 4 with `out_state` = 10 and defaults; then RUN.
- Branch priority:
  - Stimulus: `in_br_taken` = 1 together with `lu` true.
  - Response: `out_flush1` = 1, `out_bubble2` = 1, `out_pc_en` = 1; `out_state` stays 00.
- Reset mid-multiply:
  - Stimulus: `in_rst` = 0 during the second MUL_BUSY cycle.
  - Response: outputs forced to the reset values immediately; after release, `out_state` = 00 and a fresh multiply stalls the full 4 cycles.
- `HAZ_STATS_EN`:
  - Stimulus: one load-use stall plus one `MUL_LAT` = 4 multiply.
  - Response: `out_stall_cnt` = 4.
